instr_fetch: RTL

//  Upstream fetch stage for the control unit. Holds a writable instruction memory and the PC.

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch_rom.sv | 23 ++
 rtl/instr_fetch.sv | 102 ++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch stage: instruction type field codes and fetch FSM states.
package ifetch_pkg;

  localparam int IFETCH_INSTR_WIDTH = 20;
  localparam int IFETCH_PC_BITS     = 5;

  typedef enum logic [1:0] {
    TYPE_NOP_HALT = 2'b00,
    TYPE_STD      = 2'b01,
    TYPE_LOAD     = 2'b10,
    TYPE_STORE    = 2'b11
  } instr_type_e;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Program-load and instruction-delivery bus between the host/CU side (master) and the fetch stage (slave).
interface instr_fetch_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
) ();

  logic                   start;
  logic                   prog_we;
  logic [PC_BITS-1:0]     prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   halted;

  modport master (
    output start, prog_we, prog_addr, prog_data,
    input  instr, pc, busy, halted
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data,
    output instr, pc, busy, halted
  );

endinterface

// File: rtl/instr_fetch_rom.sv
// Writable instruction store for the fetch stage: synchronous write, asynchronous read.
module instr_rom #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [PC_BITS-1:0]     wr_addr,
  input  logic [INSTR_WIDTH-1:0] wr_data,
  input  logic [PC_BITS-1:0]     rd_addr,
  output logic [INSTR_WIDTH-1:0] rd_data
);

  logic [INSTR_WIDTH-1:0] mem [2**PC_BITS];

  // NOTE: the array is deliberately not reset, so programs survive rst and the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, fetch FSM tracking the CU phase sequence, and the instruction store.
// Optional feature macro: IFETCH_HALT_EN (a type-00 word fetched at write-back halts the stage).
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int INSTR_WIDTH = IFETCH_INSTR_WIDTH,
  parameter int PC_BITS     = IFETCH_PC_BITS
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.slave bus
);

  fetch_state_e           state, state_next;
  logic [PC_BITS-1:0]     pc_q, pc_next, pc_inc, rd_addr;
  logic [INSTR_WIDTH-1:0] instr_q, instr_next, rom_data, fetch_word;
  logic [1:0]             cur_type, new_type;
  logic                   rom_we;

  assign rom_we   = bus.prog_we && (state == IDLE);
  assign pc_inc   = pc_q + PC_BITS'(1);
  assign rd_addr  = (state == IDLE) ? '0 : pc_inc;
  // A write in the launch cycle must be visible to that launch, so bypass the store.
  assign fetch_word = (rom_we && (bus.prog_addr == rd_addr)) ? bus.prog_data : rom_data;
  assign cur_type = instr_q[INSTR_WIDTH-1 -: 2];
  assign new_type = fetch_word[INSTR_WIDTH-1 -: 2];

  instr_rom #(
    .INSTR_WIDTH(INSTR_WIDTH),
    .PC_BITS    (PC_BITS)
  ) u_rom (
    .clk    (clk),
    .we     (rom_we),
    .wr_addr(bus.prog_addr),
    .wr_data(bus.prog_data),
    .rd_addr(rd_addr),
    .rd_data(rom_data)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    instr_next = instr_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          instr_next = fetch_word;
          pc_next    = '0;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (cur_type == TYPE_NOP_HALT) begin
          instr_next = '0;
          state_next = IDLE;
        end else begin
          state_next = DECODE;
        end
      end
      DECODE: state_next = EXEC;
      EXEC:   state_next = (cur_type == TYPE_STD) ? WB : MEM;
      MEM:    state_next = WB;
      WB: begin
        pc_next    = pc_inc;
        instr_next = fetch_word;
`ifdef IFETCH_HALT_EN
        state_next = (new_type == TYPE_NOP_HALT) ? HALT : DECODE;
`else
        state_next = DECODE;
`endif
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      instr_q <= instr_next;
    end
  end

  assign bus.instr = instr_q;
  assign bus.pc    = pc_q;
  assign bus.busy  = (state != IDLE) && (state != HALT);
`ifdef IFETCH_HALT_EN
  assign bus.halted = (state == HALT);
`else
  assign bus.halted = 1'b0;
  logic unused_new_type;
  assign unused_new_type = ^new_type;
`endif

endmodule
